// File: rtl/psg_stereo_mixer_if.sv
// Sample output bus of the PSG stereo mixer: 16-bit stereo sample with a
// valid/ready handshake. The mixer is the master, the audio path the slave.
interface psg_stereo_mixer_if;
  logic [15:0] AUDIO_L;
  logic [15:0] AUDIO_R;
  logic        SAMPLE_VALID;
  logic        SAMPLE_READY;

  modport master (
    output AUDIO_L,
    output AUDIO_R,
    output SAMPLE_VALID,
    input  SAMPLE_READY
  );

  modport slave (
    input  AUDIO_L,
    input  AUDIO_R,
    input  SAMPLE_VALID,
    output SAMPLE_READY
  );
endinterface

// File: rtl/psg_stereo_mixer.sv
// PSG stereo mixer: pans the three channels of up to two PSG chips into
// left/right, sums the chips, box-averages over DECIM PSG clock enables and
// posts decimated 16-bit stereo samples with a sticky overrun flag.
// Optional feature macro: PSG_MIX_DCBLOCK_EN (signed DC-blocked output,
// one extra CLK of latency). Undefined by default: unsigned output.
module psg_stereo_mixer #(
  parameter int DECIM = 8
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       CE,
  input  logic [7:0] CH0_A,
  input  logic [7:0] CH0_B,
  input  logic [7:0] CH0_C,
  input  logic [7:0] CH1_A,
  input  logic [7:0] CH1_B,
  input  logic [7:0] CH1_C,
  input  logic       TS_EN,
  input  logic [1:0] STEREO,
  output logic       OVERRUN,
  input  logic       OVR_CLR,
  psg_stereo_mixer_if.master audio
);

  localparam int SHIFT = $clog2(DECIM);
  localparam int ACC_W = 11 + SHIFT;
  localparam int CNT_W = (SHIFT == 0) ? 1 : SHIFT;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

  typedef enum logic [1:0] {
    MODE_MONO = 2'b00,
    MODE_ABC  = 2'b01,
    MODE_ACB  = 2'b10,
    MODE_BAC  = 2'b11
  } stereo_mode_t;

  // Pan one chip's channels; returns {left, right}, each at most 765.
  function automatic logic [19:0] pan(input stereo_mode_t mode,
                                      input logic [7:0] a,
                                      input logic [7:0] b,
                                      input logic [7:0] c);
    logic [9:0] ea, eb, ec, l, r;
    ea = {2'b00, a};
    eb = {2'b00, b};
    ec = {2'b00, c};
    l  = '0;
    r  = '0;
    case (mode)
      MODE_MONO: begin
        l = ea + eb + ec;
        r = ea + eb + ec;
      end
      MODE_ABC: begin
        l = (ea << 1) + eb;
        r = (ec << 1) + eb;
      end
      MODE_ACB: begin
        l = (ea << 1) + ec;
        r = (eb << 1) + ec;
      end
      MODE_BAC: begin
        l = (eb << 1) + ea;
        r = (ec << 1) + ea;
      end
      default: begin
        l = '0;
        r = '0;
      end
    endcase
    return {l, r};
  endfunction

  stereo_mode_t       mode;
  logic [19:0]        pan0;
  logic [19:0]        pan1;
  logic [10:0]        mix_l;
  logic [10:0]        mix_r;
  logic [ACC_W-1:0]   acc_l;
  logic [ACC_W-1:0]   acc_r;
  logic [ACC_W-1:0]   sum_l;
  logic [ACC_W-1:0]   sum_r;
  logic [10:0]        out_l;
  logic [10:0]        out_r;
  logic [CNT_W-1:0]   cnt;
  logic               last;
  logic               new_sample;
  logic               post;
  logic [15:0]        post_l;
  logic [15:0]        post_r;

  // Pan both chips, gate chip 1 with TS_EN and form the window sum so far.
  always_comb begin
    mode       = stereo_mode_t'(STEREO);
    pan0       = pan(mode, CH0_A, CH0_B, CH0_C);
    pan1       = pan(mode, CH1_A, CH1_B, CH1_C);
    mix_l      = {1'b0, pan0[19:10]} + (TS_EN ? {1'b0, pan1[19:10]} : 11'd0);
    mix_r      = {1'b0, pan0[9:0]}   + (TS_EN ? {1'b0, pan1[9:0]}   : 11'd0);
    sum_l      = acc_l + ACC_W'(mix_l);
    sum_r      = acc_r + ACC_W'(mix_r);
    out_l      = sum_l[ACC_W-1:SHIFT];
    out_r      = sum_r[ACC_W-1:SHIFT];
    last       = (cnt == CNT_LAST);
    new_sample = CE & last;
  end

  // Box accumulator and window counter, advancing only on PSG clock enables.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      acc_l <= '0;
      acc_r <= '0;
      cnt   <= '0;
    end else if (CE) begin
      if (last) begin
        acc_l <= '0;
        acc_r <= '0;
        cnt   <= '0;
      end else begin
        acc_l <= sum_l;
        acc_r <= sum_r;
        cnt   <= cnt + 1'b1;
      end
    end
  end

`ifdef PSG_MIX_DCBLOCK_EN
  logic signed [17:0] x_l, x_r;
  logic signed [17:0] x_prev_l, x_prev_r;
  logic signed [17:0] y_prev_l, y_prev_r;
  logic signed [17:0] y_new_l, y_new_r;
  logic               post_pending;

  // Clamp the 18-bit filter state into the signed 16-bit output range.
  function automatic logic [15:0] sat16(input logic signed [17:0] y);
    logic [15:0] res;
    if (y > 18'sd32767) begin
      res = 16'h7FFF;
    end else if (y < -18'sd32768) begin
      res = 16'h8000;
    end else begin
      res = y[15:0];
    end
    return res;
  endfunction

  // One-pole DC blocker evaluated on the averaged sample of each window.
  always_comb begin
    x_l     = $signed({2'b00, out_l, 5'b00000});
    x_r     = $signed({2'b00, out_r, 5'b00000});
    y_new_l = x_l - x_prev_l + y_prev_l - (y_prev_l >>> 8);
    y_new_r = x_r - x_prev_r + y_prev_r - (y_prev_r >>> 8);
    post    = post_pending;
    post_l  = sat16(y_prev_l);
    post_r  = sat16(y_prev_r);
  end

  // Filter history updates per window; the result is posted one CLK later.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      x_prev_l     <= '0;
      x_prev_r     <= '0;
      y_prev_l     <= '0;
      y_prev_r     <= '0;
      post_pending <= 1'b0;
    end else begin
      post_pending <= new_sample;
      if (new_sample) begin
        x_prev_l <= x_l;
        x_prev_r <= x_r;
        y_prev_l <= y_new_l;
        y_prev_r <= y_new_r;
      end
    end
  end
`else
  // Without the filter the averaged sample is posted on the closing CE itself.
  always_comb begin
    post   = new_sample;
    post_l = {out_l, 5'b00000};
    post_r = {out_r, 5'b00000};
  end
`endif

  // Output holding register and valid flag of the sample handshake.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      audio.AUDIO_L      <= '0;
      audio.AUDIO_R      <= '0;
      audio.SAMPLE_VALID <= 1'b0;
    end else if (post) begin
      audio.AUDIO_L      <= post_l;
      audio.AUDIO_R      <= post_r;
      audio.SAMPLE_VALID <= 1'b1;
    end else if (audio.SAMPLE_VALID && audio.SAMPLE_READY) begin
      audio.SAMPLE_VALID <= 1'b0;
    end
  end

  // Sticky overrun when a pending sample is overwritten; setting beats clearing.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      OVERRUN <= 1'b0;
    end else if (post && audio.SAMPLE_VALID && !audio.SAMPLE_READY) begin
      OVERRUN <= 1'b1;
    end else if (OVR_CLR) begin
      OVERRUN <= 1'b0;
    end
  end

endmodule

// File: tb/tb_psg_stereo_mixer.sv
// Scoreboard bench for psg_stereo_mixer (DECIM = 8, default build).
module tb_psg_stereo_mixer;

  logic       CLK;
  logic       RESET_N;
  logic       CE;
  logic [7:0] CH0_A, CH0_B, CH0_C;
  logic [7:0] CH1_A, CH1_B, CH1_C;
  logic       TS_EN;
  logic [1:0] STEREO;
  logic       OVERRUN;
  logic       OVR_CLR;

  int testCount = 0;
  int failCount = 0;
  logic [31:0] expQ[$];

  psg_stereo_mixer_if bus ();

  psg_stereo_mixer #(.DECIM(8)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .CE      (CE),
    .CH0_A   (CH0_A),
    .CH0_B   (CH0_B),
    .CH0_C   (CH0_C),
    .CH1_A   (CH1_A),
    .CH1_B   (CH1_B),
    .CH1_C   (CH1_C),
    .TS_EN   (TS_EN),
    .STEREO  (STEREO),
    .OVERRUN (OVERRUN),
    .OVR_CLR (OVR_CLR),
    .audio   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Issue n CE ticks: CE high across one rising edge, low across the next.
  task automatic applyStimulus(input int ticks);
    for (int i = 0; i < ticks; i++) begin
      CE = 1'b1;
      @(posedge CLK); #1;
      CE = 1'b0;
      @(posedge CLK); #1;
    end
  endtask

  task automatic setChannels(input logic [7:0] a0, input logic [7:0] b0,
                             input logic [7:0] c0, input logic [7:0] a1,
                             input logic [7:0] b1, input logic [7:0] c1);
    CH0_A = a0; CH0_B = b0; CH0_C = c0;
    CH1_A = a1; CH1_B = b1; CH1_C = c1;
  endtask

  task automatic expectSample(input logic [15:0] l, input logic [15:0] r);
    expQ.push_back({l, r});
  endtask

  // Monitor: every handshake transfer is compared with the oldest expectation.
  always @(negedge CLK) begin
    if (RESET_N && bus.SAMPLE_VALID && bus.SAMPLE_READY) begin
      if (expQ.size() == 0) begin
        testCount++;
        failCount++;
        $display("[TB] FAIL unexpected sample: got 0x%0h, expected none",
                 {bus.AUDIO_L, bus.AUDIO_R});
      end else begin
        checkOutput("sample L/R", {bus.AUDIO_L, bus.AUDIO_R}, expQ.pop_front());
      end
    end
  end

  initial begin
    RESET_N = 1'b0;
    CE = 1'b0;
    OVR_CLR = 1'b0;
    TS_EN = 1'b0;
    STEREO = 2'b00;
    bus.SAMPLE_READY = 1'b1;
    setChannels(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

    // Reset held while CE toggles.
    @(posedge CLK); #1;
    setChannels(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    for (int i = 0; i < 10; i++) begin
      CE = ~CE;
      @(posedge CLK); #1;
    end
    CE = 1'b0;
    checkOutput("reset AUDIO_L", 32'(bus.AUDIO_L), 32'h0);
    checkOutput("reset AUDIO_R", 32'(bus.AUDIO_R), 32'h0);
    checkOutput("reset VALID", 32'(bus.SAMPLE_VALID), 32'h0);
    checkOutput("reset OVERRUN", 32'(OVERRUN), 32'h0);
    RESET_N = 1'b1;
    @(posedge CLK); #1;

    // ABC, chip 0 A only.
    STEREO = 2'b01;
    setChannels(8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    expectSample(16'h3FC0, 16'h0000);
    applyStimulus(7);
    checkOutput("no sample before 8th CE", 32'(bus.SAMPLE_VALID), 32'h0);
    applyStimulus(1);
    checkOutput("valid one cycle", 32'(bus.SAMPLE_VALID), 32'h0);

    // Full scale, both chips, then chip 1 disabled.
    TS_EN = 1'b1;
    setChannels(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    expectSample(16'hBF40, 16'hBF40);
    applyStimulus(8);
    TS_EN = 1'b0;
    expectSample(16'h5FA0, 16'h5FA0);
    applyStimulus(8);

    // Mono, then ACB.
    STEREO = 2'b00;
    setChannels(8'h10, 8'h10, 8'h10, 8'h00, 8'h00, 8'h00);
    expectSample(16'h0600, 16'h0600);
    applyStimulus(8);
    STEREO = 2'b10;
    setChannels(8'h10, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00);
    expectSample(16'h0800, 16'h0400);
    applyStimulus(8);

    // Mode change mid-window: averaging spans both settings.
    STEREO = 2'b00;
    setChannels(8'h10, 8'h10, 8'h10, 8'h00, 8'h00, 8'h00);
    expectSample(16'h0700, 16'h0300);
    applyStimulus(4);
    STEREO = 2'b01;
    setChannels(8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    applyStimulus(4);

    // BAC with both chips.
    STEREO = 2'b11;
    TS_EN = 1'b1;
    setChannels(8'h01, 8'h02, 8'h03, 8'h10, 8'h20, 8'h30);
    expectSample(16'h0AA0, 16'h0EE0);
    applyStimulus(8);

    // Overrun: two windows with READY low, only the second sample survives.
    TS_EN = 1'b0;
    bus.SAMPLE_READY = 1'b0;
    STEREO = 2'b00;
    setChannels(8'h10, 8'h10, 8'h10, 8'h00, 8'h00, 8'h00);
    applyStimulus(8);
    checkOutput("held sample VALID", 32'(bus.SAMPLE_VALID), 32'h1);
    checkOutput("no overrun yet", 32'(OVERRUN), 32'h0);
    STEREO = 2'b10;
    setChannels(8'h10, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00);
    expectSample(16'h0800, 16'h0400);
    applyStimulus(8);
    checkOutput("overrun set", 32'(OVERRUN), 32'h1);
    checkOutput("overwritten VALID", 32'(bus.SAMPLE_VALID), 32'h1);
    OVR_CLR = 1'b1;
    @(posedge CLK); #1;
    OVR_CLR = 1'b0;
    checkOutput("overrun cleared", 32'(OVERRUN), 32'h0);
    bus.SAMPLE_READY = 1'b1;
    @(posedge CLK); #1;
    checkOutput("valid drops after accept", 32'(bus.SAMPLE_VALID), 32'h0);

    // Reset after 5 CEs discards the partial window.
    STEREO = 2'b01;
    setChannels(8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    applyStimulus(5);
    RESET_N = 1'b0;
    @(posedge CLK); #1;
    checkOutput("mid reset AUDIO_L", 32'(bus.AUDIO_L), 32'h0);
    checkOutput("mid reset VALID", 32'(bus.SAMPLE_VALID), 32'h0);
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    expectSample(16'h3FC0, 16'h0000);
    applyStimulus(7);
    checkOutput("no sample 7 CEs after reset", 32'(bus.SAMPLE_VALID), 32'h0);
    applyStimulus(1);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 20 && expQ.size() != 0; i++) begin
      @(posedge CLK); #1;
    end
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
